// File: rtl/prince_ti_round_ctrl.sv
// rtl/prince_ti_round_ctrl.sv - round sequencer for the 3-share TI PRINCE datapath
module prince_ti_round_ctrl #(
  parameter int SBOX_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rng_valid,
  output logic       o_rng_req,
  output logic       o_load,
  output logic       o_sbox_en,
  output logic       o_sbox_inv,
  output logic       o_lin_en,
  output logic [1:0] o_lin_sel,
  output logic [3:0] o_rc_idx,
  output logic       o_final,
  output logic       o_busy,
  output logic       o_done
);

  localparam int SW = (SBOX_STAGES > 1) ? $clog2(SBOX_STAGES) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(SBOX_STAGES - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD, F_SB, F_LIN, M_SB, M_LIN, M_SBI, B_LIN, B_SBI, FINAL, DONE
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    r, r_nx;
  logic [SW-1:0] s, s_nx;
  logic          sb_last;

  // State, round and stage registers; reset aborts any operation in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      r     <= 4'd0;
      s     <= '0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
      s     <= s_nx;
    end
  end

  // Next-state and control decode; only o_sbox_en looks at i_rng_valid
  always_comb begin
    state_nx   = state;
    r_nx       = r;
    s_nx       = s;
    o_rng_req  = 1'b0;
    o_load     = 1'b0;
    o_sbox_en  = 1'b0;
    o_sbox_inv = 1'b0;
    o_lin_en   = 1'b0;
    o_lin_sel  = 2'd0;
    o_rc_idx   = 4'd0;
    o_final    = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    sb_last    = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          state_nx = LOAD;
          r_nx     = 4'd1;
          s_nx     = '0;
        end
      end

      LOAD: begin
        o_load   = 1'b1;
        o_busy   = 1'b1;
        state_nx = F_SB;
      end

      F_SB, M_SB, M_SBI, B_SBI: begin
        o_busy     = 1'b1;
        o_rng_req  = 1'b1;
        o_sbox_inv = (state == M_SBI) || (state == B_SBI);
        // Without fresh masks the whole sequencer freezes in place
        if (i_rng_valid) begin
          o_sbox_en = 1'b1;
          if (s == S_LAST) begin
            s_nx    = '0;
            sb_last = 1'b1;
          end else begin
            s_nx = s + 1'b1;
          end
        end
        if (sb_last) begin
          case (state)
            F_SB:  state_nx = F_LIN;
            M_SB:  state_nx = M_LIN;
            M_SBI: begin
              state_nx = B_LIN;
              r_nx     = 4'd6;
            end
            default: begin
              if (r == 4'd10) begin
                state_nx = FINAL;
              end else begin
                r_nx     = r + 4'd1;
                state_nx = B_LIN;
              end
            end
          endcase
        end
      end

      F_LIN: begin
        o_busy    = 1'b1;
        o_lin_en  = 1'b1;
        o_lin_sel = 2'd0;
        o_rc_idx  = r;
        if (r == 4'd5) begin
          state_nx = M_SB;
        end else begin
          r_nx     = r + 4'd1;
          state_nx = F_SB;
        end
      end

      M_LIN: begin
        o_busy    = 1'b1;
        o_lin_en  = 1'b1;
        o_lin_sel = 2'd1;
        state_nx  = M_SBI;
      end

      B_LIN: begin
        o_busy    = 1'b1;
        o_lin_en  = 1'b1;
        o_lin_sel = 2'd2;
        o_rc_idx  = r;
        state_nx  = B_SBI;
      end

      FINAL: begin
        o_busy   = 1'b1;
        o_final  = 1'b1;
        o_rc_idx = 4'd11;
        state_nx = DONE;
      end

      DONE: begin
        o_done   = 1'b1;
        r_nx     = 4'd0;
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
        r_nx     = 4'd0;
        s_nx     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_prince_ti_round_ctrl.sv
// tb/tb_prince_ti_round_ctrl.sv - self-checking bench for prince_ti_round_ctrl
module tb_prince_ti_round_ctrl;

  typedef struct packed {
    logic       rng_req;
    logic       load;
    logic       sbox_en;
    logic       sbox_inv;
    logic       lin_en;
    logic [1:0] lin_sel;
    logic [3:0] rc;
    logic       fin;
    logic       busy;
    logic       done;
  } ctl_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2, start2, valid2, rst1, start1, valid1;
  logic rq2, ld2, sen2, sinv2, len2, fin2, busy2, done2;
  logic rq1, ld1, sen1, sinv1, len1, fin1, busy1, done1;
  logic [1:0] sel2, sel1;
  logic [3:0] rc2, rc1;

  int checks = 0;
  int errors = 0;
  ctl_t ops[$];

  prince_ti_round_ctrl #(.SBOX_STAGES(2)) dut2 (
    .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_rng_valid(valid2),
    .o_rng_req(rq2), .o_load(ld2), .o_sbox_en(sen2), .o_sbox_inv(sinv2),
    .o_lin_en(len2), .o_lin_sel(sel2), .o_rc_idx(rc2), .o_final(fin2),
    .o_busy(busy2), .o_done(done2)
  );

  prince_ti_round_ctrl #(.SBOX_STAGES(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_start(start1), .i_rng_valid(valid1),
    .o_rng_req(rq1), .o_load(ld1), .o_sbox_en(sen1), .o_sbox_inv(sinv1),
    .o_lin_en(len1), .o_lin_sel(sel1), .o_rc_idx(rc1), .o_final(fin1),
    .o_busy(busy1), .o_done(done1)
  );

  // Observed controls; lin_sel and rc are only meaningful where they are consumed
  function automatic ctl_t pack(input logic rq, ld, sen, sinv, len,
                                input logic [1:0] sel, input logic [3:0] rc,
                                input logic fin, busy, done);
    ctl_t c;
    c.rng_req = rq; c.load = ld; c.sbox_en = sen; c.sbox_inv = sinv;
    c.lin_en = len; c.lin_sel = sel; c.rc = rc; c.fin = fin;
    c.busy = busy; c.done = done;
    if (!len) c.lin_sel = 2'd0;
    if (!(ld || fin || (len && sel != 2'd1))) c.rc = 4'd0;
    return c;
  endfunction

  ctl_t o2, o1;
  assign o2 = pack(rq2, ld2, sen2, sinv2, len2, sel2, rc2, fin2, busy2, done2);
  assign o1 = pack(rq1, ld1, sen1, sinv1, len1, sel1, rc1, fin1, busy1, done1);

  function automatic ctl_t c_sb(input logic inv);
    ctl_t c = '0;
    c.rng_req = 1'b1; c.sbox_en = 1'b1; c.sbox_inv = inv; c.busy = 1'b1;
    return c;
  endfunction

  function automatic ctl_t c_lin(input logic [1:0] sel, input logic [3:0] rc);
    ctl_t c = '0;
    c.lin_en = 1'b1; c.lin_sel = sel; c.rc = rc; c.busy = 1'b1;
    return c;
  endfunction

  // Reference: one entry per un-stalled cycle from LOAD to DONE
  function automatic void build_ops(input int ns);
    ctl_t c;
    ops.delete();
    c = '0; c.load = 1'b1; c.busy = 1'b1; ops.push_back(c);
    for (int rr = 1; rr <= 5; rr++) begin
      for (int k = 0; k < ns; k++) ops.push_back(c_sb(1'b0));
      ops.push_back(c_lin(2'd0, 4'(rr)));
    end
    for (int k = 0; k < ns; k++) ops.push_back(c_sb(1'b0));
    ops.push_back(c_lin(2'd1, 4'd0));
    for (int k = 0; k < ns; k++) ops.push_back(c_sb(1'b1));
    for (int rr = 6; rr <= 10; rr++) begin
      ops.push_back(c_lin(2'd2, 4'(rr)));
      for (int k = 0; k < ns; k++) ops.push_back(c_sb(1'b1));
    end
    c = '0; c.fin = 1'b1; c.rc = 4'd11; c.busy = 1'b1; ops.push_back(c);
    c = '0; c.done = 1'b1; ops.push_back(c);
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst2 = 1'b1; rst1 = 1'b1; start2 = 1'b0; start1 = 1'b0; valid2 = 1'b1; valid1 = 1'b1;
    @(negedge clk); rst2 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (o2 !== '0) begin errors++; $display("FAIL reset_idle: got %h exp %h", o2, ctl_t'('0)); end
    checks++;
    if (o1 !== '0) begin errors++; $display("FAIL reset_idle_s1: got %h exp %h", o1, ctl_t'('0)); end
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); rst2 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o2 !== '0) begin errors++; $display("FAIL start_in_reset cyc %0d: got %h exp %h", i, o2, ctl_t'('0)); end
      @(negedge clk);
    end
  endtask

  task automatic test_nominal;
    int idx = 0, lat = 0, done_lat = -1, nlin = 0, nsb = 0, ninv = 0;
    int rcs[$], sels[$];
    int rc_exp[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};
    int sel_exp[11] = '{0, 0, 0, 0, 0, 1, 2, 2, 2, 2, 2};
    bit ok;
    ctl_t e;
    build_ops(2);
    @(negedge clk); start2 = 1'b1; valid2 = 1'b1;
    #1;
    checks++;
    if (o2 !== '0) begin errors++; $display("FAIL nominal_accept: got %h exp %h", o2, ctl_t'('0)); end
    while (idx < ops.size() && lat < 100) begin
      @(negedge clk); start2 = 1'b0; valid2 = 1'b1;
      #1;
      e = ops[idx];
      checks++;
      if (o2 !== e) begin errors++; $display("FAIL nominal cyc %0d: got %h exp %h", lat, o2, e); end
      if (o2.done) done_lat = lat;
      nlin += int'(o2.lin_en);
      nsb  += int'(o2.sbox_en);
      ninv += int'(o2.sbox_en && o2.sbox_inv);
      if (o2.load || o2.fin || (o2.lin_en && o2.lin_sel != 2'd1)) rcs.push_back(int'(o2.rc));
      if (o2.lin_en) sels.push_back(int'(o2.lin_sel));
      idx++; lat++;
    end
    checks++;
    if (done_lat != 37) begin errors++; $display("FAIL nominal_latency: got %0d exp 37", done_lat); end
    checks++;
    if (nlin != 11) begin errors++; $display("FAIL lin_count: got %0d exp 11", nlin); end
    checks++;
    if (nsb != 24) begin errors++; $display("FAIL sbox_count: got %0d exp 24", nsb); end
    checks++;
    if (ninv != 12) begin errors++; $display("FAIL inv_count: got %0d exp 12", ninv); end
    ok = (rcs.size() == 12);
    if (ok) for (int i = 0; i < 12; i++) if (rcs[i] != rc_exp[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rc_sequence: got %p exp %p", rcs, rc_exp); end
    ok = (sels.size() == 11);
    if (ok) for (int i = 0; i < 11; i++) if (sels[i] != sel_exp[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL sel_sequence: got %p exp %p", sels, sel_exp); end
  endtask

  task automatic test_stall;
    int idx = 0, lat = 0, done_lat = -1, pend3 = 3, pend1 = 1;
    bit stalled;
    ctl_t e;
    build_ops(2);
    @(negedge clk); start2 = 1'b1; valid2 = 1'b1;
    while (idx < ops.size() && lat < 100) begin
      @(negedge clk); start2 = 1'b0;
      valid2 = 1'b1;
      if (idx == 4 && pend3 > 0) begin valid2 = 1'b0; pend3--; end
      if (idx == 19 && pend1 > 0) begin valid2 = 1'b0; pend1--; end
      #1;
      e = ops[idx];
      stalled = e.sbox_en && !valid2;
      if (stalled) e.sbox_en = 1'b0;
      checks++;
      if (o2 !== e) begin errors++; $display("FAIL stall cyc %0d: got %h exp %h", lat, o2, e); end
      if (o2.done) done_lat = lat;
      if (!stalled) idx++;
      lat++;
    end
    valid2 = 1'b1;
    checks++;
    if (done_lat != 41) begin errors++; $display("FAIL stall_latency: got %0d exp 41", done_lat); end
  endtask

  task automatic test_random_stall;
    for (int run = 0; run < 4; run++) begin
      int idx = 0, lat = 0, done_lat = -1, nstall = 0;
      bit stalled;
      ctl_t e;
      build_ops(2);
      @(negedge clk); start2 = 1'b1; valid2 = 1'b1;
      while (idx < ops.size() && lat < 300) begin
        @(negedge clk); start2 = 1'($urandom_range(0, 1));
        valid2 = ($urandom_range(0, 3) != 0);
        #1;
        e = ops[idx];
        stalled = e.sbox_en && !valid2;
        if (stalled) begin e.sbox_en = 1'b0; nstall++; end
        checks++;
        if (o2 !== e) begin errors++; $display("FAIL rand run %0d cyc %0d: got %h exp %h", run, lat, o2, e); end
        if (o2.done) done_lat = lat;
        if (!stalled) idx++;
        lat++;
      end
      start2 = 1'b0; valid2 = 1'b1;
      checks++;
      if (done_lat != 37 + nstall) begin
        errors++; $display("FAIL rand_latency run %0d: got %0d exp %0d", run, done_lat, 37 + nstall);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int idx = 0, lat = 0, ndone = 0;
    ctl_t e;
    build_ops(2);
    @(negedge clk); start2 = 1'b1; valid2 = 1'b1;
    while (idx < ops.size() && lat < 100) begin
      @(negedge clk);
      start2 = (lat == 10 || lat == 36 || lat == 37);
      #1;
      e = ops[idx];
      checks++;
      if (o2 !== e) begin errors++; $display("FAIL busy_start cyc %0d: got %h exp %h", lat, o2, e); end
      ndone += int'(o2.done);
      idx++; lat++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); start2 = 1'b0;
      #1;
      ndone += int'(o2.done);
      checks++;
      if (o2 !== '0) begin errors++; $display("FAIL no_restart cyc %0d: got %h exp %h", i, o2, ctl_t'('0)); end
    end
    checks++;
    if (ndone != 1) begin errors++; $display("FAIL done_count: got %0d exp 1", ndone); end
  endtask

  task automatic test_abort;
    int lat = 0, done_lat = -1;
    ctl_t e;
    build_ops(2);
    @(negedge clk); start2 = 1'b1; valid2 = 1'b1;
    for (lat = 0; lat <= 20; lat++) begin
      @(negedge clk); start2 = 1'b0;
      rst2 = (lat == 20);
      #1;
      e = ops[lat];
      checks++;
      if (o2 !== e) begin errors++; $display("FAIL abort_pre cyc %0d: got %h exp %h", lat, o2, e); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); rst2 = 1'b0;
      #1;
      checks++;
      if (o2 !== '0) begin errors++; $display("FAIL abort_idle cyc %0d: got %h exp %h", i, o2, ctl_t'('0)); end
    end
    @(negedge clk); start2 = 1'b1;
    for (lat = 0; lat < 100 && done_lat < 0; lat++) begin
      @(negedge clk); start2 = 1'b0;
      #1;
      if (o2.done) done_lat = lat;
    end
    checks++;
    if (done_lat != 37) begin errors++; $display("FAIL abort_restart_latency: got %0d exp 37", done_lat); end
  endtask

  task automatic test_back_to_back;
    ctl_t exp_q[$];
    int dl[$];
    int lat = 0;
    ctl_t e;
    build_ops(1);
    for (int run = 0; run < 3; run++) begin
      exp_q.push_back('0);
      foreach (ops[i]) exp_q.push_back(ops[i]);
    end
    @(negedge clk); start1 = 1'b1; valid1 = 1'b1;
    foreach (exp_q[i]) begin
      #1;
      e = exp_q[i];
      checks++;
      if (o1 !== e) begin errors++; $display("FAIL b2b cyc %0d: got %h exp %h", lat, o1, e); end
      if (o1.done) dl.push_back(lat);
      lat++;
      @(negedge clk);
    end
    start1 = 1'b0;
    checks++;
    if (dl.size() != 3) begin
      errors++; $display("FAIL b2b_done_count: got %0d exp 3", dl.size());
    end else begin
      checks++;
      if (dl[0] != 26 || dl[1] - dl[0] != 27 || dl[2] - dl[1] != 27) begin
        errors++; $display("FAIL b2b_spacing: got %p exp 26,53,80", dl);
      end
    end
  endtask

  initial begin
    rst2 = 1'b1; rst1 = 1'b1; start2 = 1'b0; start1 = 1'b0; valid2 = 1'b1; valid1 = 1'b1;
    test_reset();
    test_nominal();
    test_stall();
    test_start_while_busy();
    test_abort();
    test_random_stall();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
